// File: rtl/normalizer_cal_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// normalizer_cal_ctrl_pkg
//   Shared widths, reset constants, FSM state encodings and the offset
//   saturation helper used by the normalizer calibration controller.
//
//   IN_W        width of each signed accumulated channel
//   OFS_W       width of each signed offset output
//   CAL_CNT_W   width of the calibration length / sample counter
//   OFS_DEFAULT offset value after reset (largest positive OFS_W value)
// ---------------------------------------------------------------------------
package normalizer_cal_ctrl_pkg;

  localparam int IN_W      = 32;
  localparam int OFS_W     = 19;
  localparam int CAL_CNT_W = 8;

  localparam logic [OFS_W-1:0] OFS_DEFAULT = OFS_W'((2 ** (OFS_W - 1)) - 1);

  // Minimum trackers start at the largest positive value so the first
  // sample of a window always replaces it.
  localparam logic signed [IN_W-1:0] MIN_INIT = {1'b0, {(IN_W - 1){1'b1}}};

  // FSM encodings kept as plain constants for compatibility with older tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAL  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  // Clamp limits expressed in the IN_W+1 bit negation domain.
  // ~MAX == -MAX-1, i.e. the most negative OFS_W value.
  localparam logic signed [IN_W:0] OFS_MAX_EXT = {{(IN_W + 1 - OFS_W){1'b0}}, OFS_DEFAULT};
  localparam logic signed [IN_W:0] OFS_MIN_EXT = ~OFS_MAX_EXT;

  typedef struct packed {
    logic [OFS_W-1:0] ofs;
    logic             sat;
  } sat_t;

  // Returns -min_val clamped to the OFS_W signed range plus a clamp flag.
  // The negation is done one bit wider, so -2^(IN_W-1) cannot overflow and
  // simply clamps to the positive limit.
  function automatic sat_t sat_neg(input logic signed [IN_W-1:0] min_val);
    logic signed [IN_W:0] neg;
    sat_t                 res;
    neg = -{min_val[IN_W-1], min_val};
    if (neg > OFS_MAX_EXT) begin
      res.ofs = OFS_MAX_EXT[OFS_W-1:0];
      res.sat = 1'b1;
    end else if (neg < OFS_MIN_EXT) begin
      res.ofs = OFS_MIN_EXT[OFS_W-1:0];
      res.sat = 1'b1;
    end else begin
      res.ofs = neg[OFS_W-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/normalizer_cal_ctrl_if.sv
// ---------------------------------------------------------------------------
// normalizer_cal_ctrl_if
//   Bundle of the calibration request, sample strobe/data and the normalizer
//   configuration outputs.
//
//   master : drives cal_start, cal_len, stb_start, accumulated_input;
//            observes stb_start_out, offset_I/Q, cal_busy, cal_done, sat_flag
//   slave  : the controller side (directions mirrored)
// ---------------------------------------------------------------------------
interface normalizer_cal_ctrl_if;
  import normalizer_cal_ctrl_pkg::*;

  logic                   cal_start;
  logic [CAL_CNT_W-1:0]   cal_len;
  logic                   stb_start;
  logic [2*IN_W-1:0]      accumulated_input;
  logic                   stb_start_out;
  logic [OFS_W-1:0]       offset_I;
  logic [OFS_W-1:0]       offset_Q;
  logic                   cal_busy;
  logic                   cal_done;
  logic                   sat_flag;

  modport master (
    output cal_start, cal_len, stb_start, accumulated_input,
    input  stb_start_out, offset_I, offset_Q, cal_busy, cal_done, sat_flag
  );

  modport slave (
    input  cal_start, cal_len, stb_start, accumulated_input,
    output stb_start_out, offset_I, offset_Q, cal_busy, cal_done, sat_flag
  );

endinterface

// File: rtl/normalizer_cal_ctrl_min_tracker.sv
// ---------------------------------------------------------------------------
// normalizer_cal_ctrl_min_tracker
//   Running signed minimum of one channel.
//
//   clk      system clock
//   resetn   asynchronous active-low reset (min returns to max positive)
//   clr      restart tracking (min <= max positive); wins over en
//   en       fold din into the running minimum
//   din      signed sample
//   min_val  current running minimum
// ---------------------------------------------------------------------------
module normalizer_cal_ctrl_min_tracker #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] min_val
);

  localparam logic signed [W-1:0] MAX_POS = {1'b0, {(W - 1){1'b1}}};

  logic signed [W-1:0] min_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_reg <= MAX_POS;
    end else if (clr) begin
      min_reg <= MAX_POS;
    end else if (en && (din < min_reg)) begin
      min_reg <= din;
    end
  end

  assign min_val = min_reg;

endmodule

// File: rtl/normalizer_cal_ctrl.sv
// ---------------------------------------------------------------------------
// normalizer_cal_ctrl
//   Calibration controller for the I/Q normalizer. A cal_start request opens
//   a window of cal_len strobed samples (0 means 1); the per-channel minimum
//   of that window is negated, clamped to the offset width and loaded into
//   offset_I/offset_Q so the smallest observed sample maps to 0. Outside a
//   window the sample strobe is forwarded with one cycle of latency.
//
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset; aborts any calibration
//   bus     slave side of normalizer_cal_ctrl_if:
//             cal_start/cal_len      calibration request and window length
//             stb_start/accum. input sample strobe and {I,Q} data
//             stb_start_out          registered forwarded strobe
//             offset_I/offset_Q      signed offsets, change only at LOAD exit
//             cal_busy               high in CAL and LOAD
//             cal_done               one-cycle pulse with the offset update
//             sat_flag               last calibration clamped I or Q
// ---------------------------------------------------------------------------
module normalizer_cal_ctrl
  import normalizer_cal_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  normalizer_cal_ctrl_if.slave  bus
);

  logic [1:0]           state_reg;
  logic [CAL_CNT_W-1:0] len_reg;
  logic [CAL_CNT_W-1:0] cnt_reg;
  logic                 stb_out_reg;
  logic [OFS_W-1:0]     ofs_i_reg;
  logic [OFS_W-1:0]     ofs_q_reg;
  logic                 done_reg;
  logic                 sat_reg;

  logic                 trk_clr;
  logic                 trk_en;
  logic [CAL_CNT_W-1:0] cnt_next;
  logic [CAL_CNT_W-1:0] len_next;
  logic signed [IN_W-1:0] min_val [2];
  sat_t                 sat_i;
  sat_t                 sat_q;

  always_comb begin
    trk_clr  = (state_reg == ST_IDLE) && bus.cal_start;
    trk_en   = (state_reg == ST_CAL) && bus.stb_start;
    cnt_next = cnt_reg + CAL_CNT_W'(1);
    len_next = (bus.cal_len == '0) ? CAL_CNT_W'(1) : bus.cal_len;
    sat_i    = sat_neg(min_val[1]);
    sat_q    = sat_neg(min_val[0]);
  end

  // Channel gi = 0 is Q (low half), gi = 1 is I (high half).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_trk
      normalizer_cal_ctrl_min_tracker #(
        .W (IN_W)
      ) u_trk (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (trk_clr),
        .en      (trk_en),
        .din     (bus.accumulated_input[gi*IN_W +: IN_W]),
        .min_val (min_val[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      len_reg     <= CAL_CNT_W'(1);
      cnt_reg     <= '0;
      stb_out_reg <= 1'b0;
      ofs_i_reg   <= OFS_DEFAULT;
      ofs_q_reg   <= OFS_DEFAULT;
      done_reg    <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A strobe coincident with cal_start is still forwarded; the
          // trackers are being cleared on this edge so it is not counted.
          stb_out_reg <= bus.stb_start;
          if (bus.cal_start) begin
            len_reg   <= len_next;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            state_reg <= ST_CAL;
          end
        end
        ST_CAL: begin
          // Window samples are withheld from the NN path.
          stb_out_reg <= 1'b0;
          if (bus.stb_start) begin
            cnt_reg <= cnt_next;
            if (cnt_next == len_reg) begin
              state_reg <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // The last window sample has been folded into the trackers on the
          // previous edge, so the minima are final here.
          stb_out_reg <= 1'b0;
          ofs_i_reg   <= sat_i.ofs;
          ofs_q_reg   <= sat_q.ofs;
          sat_reg     <= sat_i.sat | sat_q.sat;
          done_reg    <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: begin
          stb_out_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stb_start_out = stb_out_reg;
  assign bus.offset_I      = ofs_i_reg;
  assign bus.offset_Q      = ofs_q_reg;
  assign bus.cal_busy      = (state_reg == ST_CAL) || (state_reg == ST_LOAD);
  assign bus.cal_done      = done_reg;
  assign bus.sat_flag      = sat_reg;

endmodule

// File: tb/tb_normalizer_cal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_normalizer_cal_ctrl
//   Directed stimulus with a scoreboard: each expected forwarded strobe or
//   calibration completion is queued with its cycle; a monitor pops and
//   compares whenever the DUT raises stb_start_out or cal_done.
// ---------------------------------------------------------------------------
module tb_normalizer_cal_ctrl;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  typedef struct {
    logic        done;
    int          cyc;
    logic [18:0] oi;
    logic [18:0] oq;
    logic        sat;
  } exp_t;

  exp_t sb[$];

  normalizer_cal_ctrl_if ifc ();

  normalizer_cal_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per observed transaction, compared against the queue.
  task automatic mon_pop(input logic is_done);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL unexpected_%s: output seen at cycle %0d with nothing expected",
               is_done ? "cal_done" : "stb_out", cyc);
    end else begin
      e = sb.pop_front();
      $display("mon: %s cycle %0d oI=%0h oQ=%0h sat=%0b", is_done ? "cal_done" : "stb_out",
               cyc, ifc.offset_I, ifc.offset_Q, ifc.sat_flag);
      chk("kind", 64'(is_done), 64'(e.done));
      chk("cycle", 64'(cyc), 64'(e.cyc));
      if (is_done) begin
        chk("offset_I", 64'(ifc.offset_I), 64'(e.oi));
        chk("offset_Q", 64'(ifc.offset_Q), 64'(e.oq));
        chk("sat_flag", 64'(ifc.sat_flag), 64'(e.sat));
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (ifc.stb_start_out) mon_pop(1'b0);
      if (ifc.cal_done)      mon_pop(1'b1);
    end
  end

  // One clock of stimulus; returns 1 ns after the sampling edge.
  task automatic drive(input logic cs, input logic [7:0] len, input logic stb,
                       input int i_val, input int q_val, input logic fwd);
    exp_t e;
    ifc.cal_start         = cs;
    ifc.cal_len           = len;
    ifc.stb_start         = stb;
    ifc.accumulated_input = {i_val[31:0], q_val[31:0]};
    @(posedge clk);
    #1;
    ifc.cal_start = 1'b0;
    ifc.stb_start = 1'b0;
    if (fwd) begin
      e = '{done: 1'b0, cyc: cyc, oi: '0, oq: '0, sat: 1'b0};
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'd0, 1'b0, 0, 0, 1'b0);
  endtask

  // Call right after the strobe that completes a window.
  task automatic expect_done(input int oi, input int oq, input logic sat);
    exp_t e;
    e = '{done: 1'b1, cyc: cyc + 1, oi: oi[18:0], oq: oq[18:0], sat: sat};
    sb.push_back(e);
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_offset_I"}, 64'(ifc.offset_I), 64'd262143);
    chk({tag, "_offset_Q"}, 64'(ifc.offset_Q), 64'd262143);
    chk({tag, "_stb_out"},  64'(ifc.stb_start_out), 64'd0);
    chk({tag, "_busy"},     64'(ifc.cal_busy), 64'd0);
    chk({tag, "_done"},     64'(ifc.cal_done), 64'd0);
    chk({tag, "_sat"},      64'(ifc.sat_flag), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.cal_start         = 1'b0;
    ifc.cal_len           = 8'd0;
    ifc.stb_start         = 1'b0;
    ifc.accumulated_input = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_defaults("reset");
    resetn = 1'b1;
    idle(1);

    // IDLE forwarding, 4 cycles apart.
    drive(1'b0, 8'd0, 1'b1, 11, 22, 1'b1);
    idle(3);
    drive(1'b0, 8'd0, 1'b1, -5, 6, 1'b1);
    idle(2);
    chk("idle_offset_I", 64'(ifc.offset_I), 64'd262143);

    // Window of 4: minI=-300 -> 300, minQ=5 -> -5.
    drive(1'b1, 8'd4, 1'b0, 0, 0, 1'b0);
    chk("cal_busy", 64'(ifc.cal_busy), 64'd1);
    drive(1'b0, 8'd0, 1'b1, -100, 10, 1'b0);
    idle(1);
    drive(1'b0, 8'd0, 1'b1, 50, 5, 1'b0);
    drive(1'b0, 8'd0, 1'b1, -300, 7, 1'b0);
    idle(1);
    drive(1'b0, 8'd0, 1'b1, 20, 9, 1'b0);
    expect_done(300, -5, 1'b0);
    idle(4);
    chk("post_cal_busy", 64'(ifc.cal_busy), 64'd0);
    chk("stable_offset_I", 64'(ifc.offset_I), 64'(19'd300));

    // Saturation in both directions.
    drive(1'b1, 8'd1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, -1000000, 1000000, 1'b0);
    expect_done(262143, -262144, 1'b1);
    idle(3);
    chk("sat_sticky", 64'(ifc.sat_flag), 64'd1);

    // len=0 with a coincident strobe (forwarded, not counted), then a
    // cal_start inside the window that must be ignored.
    drive(1'b1, 8'd0, 1'b1, -999999, -999999, 1'b1);
    chk("sat_cleared", 64'(ifc.sat_flag), 64'd0);
    idle(1);
    drive(1'b1, 8'd5, 1'b0, 0, 0, 1'b0);
    idle(1);
    drive(1'b0, 8'd0, 1'b1, 7, -3, 1'b0);
    expect_done(-7, 3, 1'b0);
    idle(4);

    // Abort after 2 of 4 strobes.
    drive(1'b1, 8'd4, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, -40, -40, 1'b0);
    drive(1'b0, 8'd0, 1'b1, -50, -50, 1'b0);
    #2 resetn = 1'b0;
    #1 chk_defaults("abort");
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(2);

    // Fresh window after the abort.
    drive(1'b1, 8'd2, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 5, -1, 1'b0);
    drive(1'b0, 8'd0, 1'b1, -8, -2, 1'b0);
    expect_done(8, 2, 1'b0);
    idle(3);
    drive(1'b0, 8'd0, 1'b1, 1, 1, 1'b1);
    idle(4);

    chk("pending", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
